// File: rtl/dilithium_prod_issuer_if.sv
// rtl/dilithium_prod_issuer_if.sv - operand-pair input and product output handshake bundle
interface dilithium_prod_issuer_if #(
   parameter int IDX_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [22:0]      in_a;
   logic [22:0]      in_b;
   logic             out_valid;
   logic             out_ready;
   logic [45:0]      out_prod;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_prod, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_prod, out_idx, out_last
   );
endinterface

// File: rtl/dilithium_prod_issuer.sv
// rtl/dilithium_prod_issuer.sv - two-stage 23x23 multiplier issuing indexed products to the reducer
module dilithium_prod_issuer #(
   parameter int Q     = 8380417,
   parameter int N     = 256,
   parameter int IDX_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   dilithium_prod_issuer_if.slave   bus,
   output logic                     range_err,
   output logic                     busy
);
   localparam logic [22:0]      Q_V      = 23'(Q);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   logic             s1_valid;
   logic [22:0]      s1_a;
   logic [22:0]      s1_b;
   logic [IDX_W-1:0] s1_idx;
   logic [IDX_W-1:0] idx_cnt;

   logic             s2_valid;
   logic [45:0]      s2_prod;
   logic [IDX_W-1:0] s2_idx;
   logic             s2_last;

   logic             s2_adv;
   logic             s1_adv;

   // in_ready depends on out_ready but never on in_valid
   assign s2_adv      = s1_valid & (~s2_valid | bus.out_ready);
   assign bus.in_ready = ~s1_valid | s2_adv;
   assign s1_adv      = bus.in_valid & bus.in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_idx    <= '0;
         idx_cnt   <= '0;
         s2_valid  <= 1'b0;
         s2_prod   <= '0;
         s2_idx    <= '0;
         s2_last   <= 1'b0;
         range_err <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
            s1_idx   <= idx_cnt;
            idx_cnt  <= (idx_cnt == IDX_LAST) ? '0 : idx_cnt + 1'b1;
            if ((bus.in_a >= Q_V) || (bus.in_b >= Q_V))
               range_err <= 1'b1;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end

         // operands out of range are still multiplied; 2^23-1 squared fits in 46 bits
         if (s2_adv) begin
            s2_valid <= 1'b1;
            s2_prod  <= {23'd0, s1_a} * {23'd0, s1_b};
            s2_idx   <= s1_idx;
            s2_last  <= (s1_idx == IDX_LAST);
         end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out_prod  = s2_prod;
   assign bus.out_idx   = s2_idx;
   assign bus.out_last  = s2_last;
   assign busy          = s1_valid | s2_valid;
endmodule

// File: tb/tb_dilithium_prod_issuer.sv
// tb/tb_dilithium_prod_issuer.sv - scoreboard bench for dilithium_prod_issuer
module tb_dilithium_prod_issuer;
   localparam int          Q = 8380417;
   localparam int          N = 256;

   typedef struct {
      logic [63:0] prod;
      int          idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic range_err;
   logic busy;

   dilithium_prod_issuer_if #(.IDX_W(8)) bus ();

   dilithium_prod_issuer #(.Q(Q), .N(N), .IDX_W(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .range_err(range_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_mis = 0;
   int          model_cnt = 0;
   logic        model_range = 1'b0;
   bit          rand_ready = 1'b0;
   int          cyc = 0;
   int          pop_n = 0;
   int          first_pop = 0;
   int          last_pop = 0;
   bit          stall_prev = 1'b0;
   logic [45:0] held_prod;
   logic [7:0]  held_idx;
   logic        held_last;
   bit          bp_done;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // reference model: product and index derived from the accepted-pair count
   task automatic push(input logic [22:0] a, input logic [22:0] b);
      exp_t e;
      e.prod = 64'(a) * 64'(b);
      e.idx  = model_cnt % N;
      model_cnt++;
      if (int'(a) >= Q || int'(b) >= Q) model_range = 1'b1;
      sb.push_back(e);
   endtask

   task automatic send(input logic [22:0] a, input logic [22:0] b);
      int t = 0;
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a = a;
      bus.in_b = b;
      while (!ok && t < 300) begin
         @(negedge clk);
         if (bus.in_ready) begin
            push(a, b);
            ok = 1'b1;
         end
         @(posedge clk); #1;
         t++;
      end
      if (!ok) chk("send_timeout", 64'(t), 64'(0));
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_empty", 64'(sb.size()), 64'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      model_cnt = 0;
      model_range = 1'b0;
      rst_n = 1'b1;
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 6);
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", 64'(bus.out_valid), 64'(1));
            chk("stall_prod", 64'(bus.out_prod), 64'(held_prod));
            chk("stall_idx", 64'(bus.out_idx), 64'(held_idx));
            chk("stall_last", 64'(bus.out_last), 64'(held_last));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 64'(1), 64'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_prod", 64'(bus.out_prod), e.prod);
               chk("out_idx", 64'(bus.out_idx), 64'(e.idx));
               chk("out_last", 64'(bus.out_last), 64'(e.idx == N - 1));
               if (pop_n == 0) first_pop = cyc;
               last_pop = cyc;
               pop_n++;
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held_prod  = bus.out_prod;
         held_idx   = bus.out_idx;
         held_last  = bus.out_last;
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.out_ready = 1'b1;
      do_reset();

      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_range_err", 64'(range_err), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_out_prod", 64'(bus.out_prod), 64'(0));
      chk("rst_out_idx", 64'(bus.out_idx), 64'(0));
      chk("rst_out_last", 64'(bus.out_last), 64'(0));

      send(23'd8380416, 23'd8380416);
      chk("lat_not_yet", 64'(bus.out_valid), 64'(0));
      chk("lat_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
      chk("lat_valid", 64'(bus.out_valid), 64'(1));
      chk("max_prod", 64'(bus.out_prod), 64'd70231372333056);
      chk("max_idx", 64'(bus.out_idx), 64'(0));
      chk("max_range_err", 64'(range_err), 64'(0));
      drain();

      do_reset();
      pop_n = 0;
      for (int i = 0; i < N; i++) send(23'(i), 23'd2);
      send(23'd7, 23'd2);
      drain();
      chk("stream_count", 64'(pop_n), 64'(N + 1));
      chk("stream_gapless", 64'(last_pop - first_pop), 64'(N));

      do_reset();
      pop_n = 0;
      bus.out_ready = 1'b0;
      bp_done = 1'b0;
      fork
         begin
            for (int i = 1; i <= 5; i++) send(23'(i), 23'd3);
            bp_done = 1'b1;
         end
      join_none
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
         chk("bp_hold_prod", 64'(bus.out_prod), 64'(3));
      end
      chk("bp_accepts", 64'(sb.size()), 64'(2));
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 100 && !bp_done; t++) begin
         @(posedge clk); #1;
      end
      chk("bp_sender_done", 64'(bp_done), 64'(1));
      drain();
      chk("bp_count", 64'(pop_n), 64'(5));
      chk("bp_gapless", 64'(last_pop - first_pop), 64'(4));

      do_reset();
      rand_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [22:0] a;
         logic [22:0] b;
         a = 23'($urandom_range(0, Q - 1));
         b = 23'($urandom_range(0, Q - 1));
         if ($urandom_range(0, 31) == 0) a = 23'($urandom_range(0, 8388607));
         if ($urandom_range(0, 31) == 0) b = 23'($urandom_range(0, 8388607));
         send(a, b);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      rand_ready = 1'b0;
      bus.out_ready = 1'b1;
      drain();
      chk("rand_range_err", 64'(range_err), 64'(model_range));

      do_reset();
      send(23'd8380417, 23'd1);
      chk("range_set", 64'(range_err), 64'(1));
      for (int i = 0; i < 3; i++) send(23'(100 + i), 23'd5);
      drain();
      chk("range_sticky", 64'(range_err), 64'(1));

      bus.out_ready = 1'b0;
      send(23'd11, 23'd12);
      send(23'd13, 23'd14);
      chk("flight_busy", 64'(busy), 64'(1));
      do_reset();
      chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
      chk("flush_busy", 64'(busy), 64'(0));
      chk("flush_range_err", 64'(range_err), 64'(0));
      bus.out_ready = 1'b1;
      send(23'd5, 23'd6);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
